// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter
//   Round-robin arbiter that lets NUM_REQ byte-stream requesters share one
//   UART TX FIFO. A requester keeps the lock for a whole message, from its
//   grant up to and including the byte flagged with req_last_i.
//
//   Optional macro UART_TX_ARB_TIMEOUT_EN: adds a stall counter that forcibly
//   releases a lock after TIMEOUT_CYCLES locked cycles without a transfer.
//
//   Ports
//     clk_i            system clock, rising edge
//     reset_i          asynchronous, active-high reset
//     req_valid_i      per-requester byte valid
//     req_data_i       per-requester byte, requester k at [8k+7:8k]
//     req_last_i       final byte of the requester's message
//     req_ready_o      per-requester accept (combinational)
//     tx_fifo_full_i   TX FIFO full
//     tx_fifo_afull_i  TX FIFO has exactly one free entry
//     tx_fifo_wen_o    registered FIFO write strobe
//     tx_fifo_wdata_o  registered FIFO write data
//     grant_o          one-hot lock owner, zero when unlocked
//     arb_busy_o       a requester holds the lock
//     timeout_o        one-cycle pulse on a forced release
//
//   state  | meaning
//   -------+------------------------------------------------------------
//   IDLE   | no owner; pick the first valid requester at/after rr_ptr
//   LOCKED | owner in grant_o; its bytes are forwarded to the FIFO

module uart_tx_arbiter #(
    parameter int NUM_REQ        = 4,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                   clk_i,
    input  logic                   reset_i,
    input  logic [NUM_REQ-1:0]     req_valid_i,
    input  logic [8*NUM_REQ-1:0]   req_data_i,
    input  logic [NUM_REQ-1:0]     req_last_i,
    output logic [NUM_REQ-1:0]     req_ready_o,
    input  logic                   tx_fifo_full_i,
    input  logic                   tx_fifo_afull_i,
    output logic                   tx_fifo_wen_o,
    output logic [7:0]             tx_fifo_wdata_o,
    output logic [NUM_REQ-1:0]     grant_o,
    output logic                   arb_busy_o,
    output logic                   timeout_o
);

    localparam int IDXW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    if (NUM_REQ < 2 || NUM_REQ > 8 || TIMEOUT_CYCLES < 1) begin : g_param_check
        $error("uart_tx_arbiter: illegal parameter value");
    end

    typedef enum logic {IDLE = 1'b0, LOCKED = 1'b1} state_t;

    state_t             state_q, state_d;
    logic [IDXW-1:0]    rr_ptr_q, rr_ptr_d;
    logic [IDXW-1:0]    gidx_q, gidx_d;
    logic [NUM_REQ-1:0] grant_q, grant_d;
    logic               wen_q, wen_d;
    logic [7:0]         wdata_q, wdata_d;

    logic [IDXW-1:0]    pick_idx;
    logic [IDXW-1:0]    scan_idx;
    logic               pick_found;
    logic               can_write;
    logic               xfer;
    logic               xfer_last;
    logic               stall_expired;

    function automatic logic [IDXW-1:0] wrap_inc(input logic [IDXW-1:0] i);
        if (i == IDXW'(NUM_REQ - 1)) return '0;
        return i + IDXW'(1);
    endfunction

    // Rotating priority scan starting at rr_ptr.
    always_comb begin
        pick_found = 1'b0;
        pick_idx   = '0;
        scan_idx   = rr_ptr_q;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (!pick_found && req_valid_i[scan_idx]) begin
                pick_found = 1'b1;
                pick_idx   = scan_idx;
            end
            scan_idx = wrap_inc(scan_idx);
        end
    end

    // A write already in flight consumes the last free entry when afull.
    assign can_write   = !tx_fifo_full_i && !(wen_q && tx_fifo_afull_i);
    assign req_ready_o = (state_q == LOCKED && can_write) ? grant_q : '0;
    assign xfer        = |(req_valid_i & req_ready_o);
    assign xfer_last   = xfer && req_last_i[gidx_q];

    always_comb begin
        state_d  = state_q;
        rr_ptr_d = rr_ptr_q;
        gidx_d   = gidx_q;
        grant_d  = grant_q;
        wen_d    = xfer;
        wdata_d  = wdata_q;
        if (xfer) begin
            wdata_d = req_data_i[{gidx_q, 3'b000} +: 8];
        end
        case (state_q)
            IDLE: begin
                if (pick_found) begin
                    state_d = LOCKED;
                    gidx_d  = pick_idx;
                    grant_d = NUM_REQ'(1) << pick_idx;
                end
            end
            LOCKED: begin
                if (xfer_last || stall_expired) begin
                    state_d  = IDLE;
                    grant_d  = '0;
                    rr_ptr_d = wrap_inc(gidx_q);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q  <= IDLE;
            rr_ptr_q <= '0;
            gidx_q   <= '0;
            grant_q  <= '0;
            wen_q    <= 1'b0;
            wdata_q  <= '0;
        end else begin
            state_q  <= state_d;
            rr_ptr_q <= rr_ptr_d;
            gidx_q   <= gidx_d;
            grant_q  <= grant_d;
            wen_q    <= wen_d;
            wdata_q  <= wdata_d;
        end
    end

`ifdef UART_TX_ARB_TIMEOUT_EN
    localparam int CNTW = $clog2(TIMEOUT_CYCLES + 1);

    logic [CNTW-1:0] stall_cnt_q;
    logic            timeout_q;

    // Counter is held at zero outside LOCKED, so every grant starts from zero.
    assign stall_expired = (state_q == LOCKED) && !xfer &&
                           (stall_cnt_q == CNTW'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            stall_cnt_q <= '0;
            timeout_q   <= 1'b0;
        end else begin
            timeout_q <= stall_expired;
            if (state_q != LOCKED || xfer || stall_expired) begin
                stall_cnt_q <= '0;
            end else begin
                stall_cnt_q <= stall_cnt_q + CNTW'(1);
            end
        end
    end

    assign timeout_o = timeout_q;
`else
    assign stall_expired = 1'b0;
    assign timeout_o     = 1'b0;
`endif

    assign grant_o         = grant_q;
    assign arb_busy_o      = (state_q == LOCKED);
    assign tx_fifo_wen_o   = wen_q;
    assign tx_fifo_wdata_o = wdata_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
module tb_uart_tx_arbiter;

    logic        clk_i = 1'b0;
    logic        reset_i;
    logic [3:0]  req_valid_i;
    logic [31:0] req_data_i;
    logic [3:0]  req_last_i;
    logic [3:0]  req_ready_o;
    logic        tx_fifo_full_i;
    logic        tx_fifo_afull_i;
    logic        tx_fifo_wen_o;
    logic [7:0]  tx_fifo_wdata_o;
    logic [3:0]  grant_o;
    logic        arb_busy_o;
    logic        timeout_o;

    int errors = 0;
    int checks = 0;

    always #5 clk_i = ~clk_i;

    uart_tx_arbiter #(.NUM_REQ(4), .TIMEOUT_CYCLES(8)) dut (
        .clk_i           (clk_i),
        .reset_i         (reset_i),
        .req_valid_i     (req_valid_i),
        .req_data_i      (req_data_i),
        .req_last_i      (req_last_i),
        .req_ready_o     (req_ready_o),
        .tx_fifo_full_i  (tx_fifo_full_i),
        .tx_fifo_afull_i (tx_fifo_afull_i),
        .tx_fifo_wen_o   (tx_fifo_wen_o),
        .tx_fifo_wdata_o (tx_fifo_wdata_o),
        .grant_o         (grant_o),
        .arb_busy_o      (arb_busy_o),
        .timeout_o       (timeout_o)
    );

    typedef struct {
        logic [3:0]  valid;
        logic [3:0]  last;
        logic        full;
        logic        afull;
        logic [31:0] data;
        logic [3:0]  ready;
        logic [3:0]  grant;
        logic        busy;
        logic        wen;
        logic [7:0]  wdata;
    } vec_t;

    vec_t vq[$];

    task automatic add(input logic [3:0] valid, input logic [3:0] last,
                       input logic full, input logic afull, input logic [31:0] data,
                       input logic [3:0] ready, input logic [3:0] grant,
                       input logic busy, input logic wen, input logic [7:0] wdata);
        vec_t v;
        v.valid = valid; v.last = last; v.full = full; v.afull = afull; v.data = data;
        v.ready = ready; v.grant = grant; v.busy = busy; v.wen = wen; v.wdata = wdata;
        vq.push_back(v);
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk_i);
        #1;
    endtask

    task automatic drive(input logic [3:0] valid, input logic [3:0] last, input logic [31:0] data);
        req_valid_i = valid;
        req_last_i  = last;
        req_data_i  = data;
    endtask

    task automatic chk_regs(input string name, input logic [3:0] grant, input logic busy,
                            input logic wen, input logic [7:0] wdata);
        chk({name, " grant"}, 32'(grant_o), 32'(grant));
        chk({name, " busy"},  32'(arb_busy_o), 32'(busy));
        chk({name, " wen"},   32'(tx_fifo_wen_o), 32'(wen));
        chk({name, " wdata"}, 32'(tx_fifo_wdata_o), 32'(wdata));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1);
    end

    initial begin
        reset_i = 1'b1;
        drive(4'b0000, 4'b0000, 32'h0);
        tx_fifo_full_i  = 1'b0;
        tx_fifo_afull_i = 1'b0;

        //   valid    last     f  af  data          ready    grant    b  w  wdata
        add(4'b0000, 4'b0000, 0, 0, 32'h00000000, 4'b0000, 4'b0000, 0, 0, 8'h00);
        add(4'b0001, 4'b0000, 0, 0, 32'h00000041, 4'b0000, 4'b0001, 1, 0, 8'h00);
        add(4'b0001, 4'b0000, 0, 0, 32'h00000041, 4'b0001, 4'b0001, 1, 1, 8'h41);
        add(4'b0001, 4'b0000, 0, 0, 32'h00000042, 4'b0001, 4'b0001, 1, 1, 8'h42);
        add(4'b0001, 4'b0001, 0, 0, 32'h00000043, 4'b0001, 4'b0000, 0, 1, 8'h43);
        add(4'b0000, 4'b0000, 0, 0, 32'h00000000, 4'b0000, 4'b0000, 0, 0, 8'h43);
        add(4'b0101, 4'b0000, 0, 0, 32'h00c000a0, 4'b0000, 4'b0100, 1, 0, 8'h43);
        add(4'b0101, 4'b0100, 0, 0, 32'h00c000a0, 4'b0100, 4'b0000, 0, 1, 8'hc0);
        add(4'b0101, 4'b0000, 0, 0, 32'h00c000a0, 4'b0000, 4'b0001, 1, 0, 8'hc0);
        add(4'b0101, 4'b0001, 0, 0, 32'h00c000a0, 4'b0001, 4'b0000, 0, 1, 8'ha0);
        add(4'b0010, 4'b0000, 0, 0, 32'h0000b100, 4'b0000, 4'b0010, 1, 0, 8'ha0);
        add(4'b0010, 4'b0000, 0, 1, 32'h0000b100, 4'b0010, 4'b0010, 1, 1, 8'hb1);
        add(4'b0010, 4'b0000, 0, 1, 32'h0000b200, 4'b0000, 4'b0010, 1, 0, 8'hb1);
        add(4'b0010, 4'b0000, 1, 0, 32'h0000b200, 4'b0000, 4'b0010, 1, 0, 8'hb1);
        add(4'b0000, 4'b0000, 1, 0, 32'h00000000, 4'b0000, 4'b0010, 1, 0, 8'hb1);
        add(4'b0000, 4'b0000, 0, 0, 32'h00000000, 4'b0010, 4'b0010, 1, 0, 8'hb1);
        add(4'b1010, 4'b0010, 0, 0, 32'h0000b200, 4'b0010, 4'b0000, 0, 1, 8'hb2);
        add(4'b1000, 4'b0000, 0, 0, 32'hd0000000, 4'b0000, 4'b1000, 1, 0, 8'hb2);
        add(4'b1000, 4'b1000, 0, 0, 32'hd0000000, 4'b1000, 4'b0000, 0, 1, 8'hd0);
        add(4'b1111, 4'b1111, 0, 0, 32'h13121110, 4'b0000, 4'b0001, 1, 0, 8'hd0);
        add(4'b1111, 4'b1111, 0, 0, 32'h13121110, 4'b0001, 4'b0000, 0, 1, 8'h10);
        add(4'b1111, 4'b1111, 0, 0, 32'h13121110, 4'b0000, 4'b0010, 1, 0, 8'h10);
        add(4'b1111, 4'b1111, 0, 0, 32'h13121110, 4'b0010, 4'b0000, 0, 1, 8'h11);
        add(4'b1111, 4'b1111, 0, 0, 32'h13121110, 4'b0000, 4'b0100, 1, 0, 8'h11);
        add(4'b1111, 4'b1111, 0, 0, 32'h13121110, 4'b0100, 4'b0000, 0, 1, 8'h12);
        add(4'b1111, 4'b1111, 0, 0, 32'h13121110, 4'b0000, 4'b1000, 1, 0, 8'h12);
        add(4'b1111, 4'b1111, 0, 0, 32'h13121110, 4'b1000, 4'b0000, 0, 1, 8'h13);
        add(4'b1111, 4'b1111, 0, 0, 32'h13121110, 4'b0000, 4'b0001, 1, 0, 8'h13);
        add(4'b1111, 4'b1111, 0, 0, 32'h13121110, 4'b0001, 4'b0000, 0, 1, 8'h10);

        // Reset state
        #2;
        chk_regs("reset", 4'b0000, 1'b0, 1'b0, 8'h00);
        chk("reset ready",   32'(req_ready_o), 32'h0);
        chk("reset timeout", 32'(timeout_o), 32'h0);
        tick;
        reset_i = 1'b0;

        // Table: inputs held for one cycle, ready sampled mid-cycle,
        // registered outputs sampled after the following edge.
        foreach (vq[i]) begin
            drive(vq[i].valid, vq[i].last, vq[i].data);
            tx_fifo_full_i  = vq[i].full;
            tx_fifo_afull_i = vq[i].afull;
            #1;
            chk($sformatf("v%0d ready", i), 32'(req_ready_o), 32'(vq[i].ready));
            tick;
            chk_regs($sformatf("v%0d", i), vq[i].grant, vq[i].busy, vq[i].wen, vq[i].wdata);
            chk($sformatf("v%0d timeout", i), 32'(timeout_o), 32'h0);
        end
        tx_fifo_full_i  = 1'b0;
        tx_fifo_afull_i = 1'b0;

        // Reset mid-message: rr_ptr is 1 here, so req1 owns the lock.
        drive(4'b0010, 4'b0000, 32'h0000e100);
        tick;
        chk("mid grant", 32'(grant_o), 32'h2);
        tick;
        chk_regs("mid byte1", 4'b0010, 1'b1, 1'b1, 8'he1);
        drive(4'b0010, 4'b0000, 32'h0000e200);
        #2;
        chk("mid ready before reset", 32'(req_ready_o), 32'h2);
        reset_i = 1'b1;
        #1;
        chk_regs("async reset", 4'b0000, 1'b0, 1'b0, 8'h00);
        chk("async reset ready",   32'(req_ready_o), 32'h0);
        chk("async reset timeout", 32'(timeout_o), 32'h0);
        tick;
        chk_regs("reset held", 4'b0000, 1'b0, 1'b0, 8'h00);
        reset_i = 1'b0;
        drive(4'b0011, 4'b0000, 32'h0000e2a1);
        #1;
        chk("post reset ready", 32'(req_ready_o), 32'h0);
        tick;
        chk_regs("post reset grant", 4'b0001, 1'b1, 1'b0, 8'h00);
        drive(4'b0011, 4'b0001, 32'h0000e2a1);
        tick;
        chk_regs("post reset byte", 4'b0000, 1'b0, 1'b1, 8'ha1);

        // Stall: req1 granted then drops valid, req3 waits.
        drive(4'b1010, 4'b0000, 32'h0);
        tick;
        chk("stall grant", 32'(grant_o), 32'h2);
        drive(4'b1000, 4'b0000, 32'hd5000000);
`ifdef UART_TX_ARB_TIMEOUT_EN
        for (int k = 1; k <= 7; k++) begin
            tick;
            chk($sformatf("stall c%0d grant", k), 32'(grant_o), 32'h2);
            chk($sformatf("stall c%0d timeout", k), 32'(timeout_o), 32'h0);
        end
        tick;
        chk("timeout pulse", 32'(timeout_o), 32'h1);
        chk("timeout grant", 32'(grant_o), 32'h0);
        chk("timeout busy",  32'(arb_busy_o), 32'h0);
        chk("timeout wen",   32'(tx_fifo_wen_o), 32'h0);
        tick;
        chk("timeout end", 32'(timeout_o), 32'h0);
        chk("regrant req3", 32'(grant_o), 32'h8);
`else
        for (int k = 1; k <= 12; k++) begin
            tick;
            chk($sformatf("hold c%0d grant", k), 32'(grant_o), 32'h2);
            chk($sformatf("hold c%0d timeout", k), 32'(timeout_o), 32'h0);
        end
        drive(4'b1010, 4'b0010, 32'hd500c500);
        #1;
        chk("hold release ready", 32'(req_ready_o), 32'h2);
        tick;
        chk_regs("hold release", 4'b0000, 1'b0, 1'b1, 8'hc5);
        drive(4'b1000, 4'b0000, 32'hd5000000);
        tick;
        chk("regrant req3", 32'(grant_o), 32'h8);
`endif
        drive(4'b1000, 4'b1000, 32'hd5000000);
        tick;
        chk_regs("req3 byte", 4'b0000, 1'b0, 1'b1, 8'hd5);
        drive(4'b0000, 4'b0000, 32'h0);
        tick;
        chk("final wen", 32'(tx_fifo_wen_o), 32'h0);
        chk("final wdata held", 32'(tx_fifo_wdata_o), 32'hd5);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/uart_tx_arbiter.md
UART_TX_ARBITER -- requirements
Module: uart_tx_arbiter

Interface
REQ-001 SHALL have parameter NUM_REQ, default 4, meaning number of byte-stream requesters (legal range 2..8).
REQ-002 SHALL have parameter TIMEOUT_CYCLES, default 1024, meaning the stall limit used only when UART_TX_ARB_TIMEOUT_EN is defined.
REQ-003 SHALL have port clk_i  input  1  system clock; all logic runs on rising edge.
REQ-004 SHALL have port reset_i  input  1  reset, asynchronous and active-high.
REQ-005 SHALL have port req_valid_i  input  NUM_REQ  per-requester byte valid.
REQ-006 SHALL have port req_data_i  input  8*NUM_REQ  per-requester byte; requester k occupies bits [8k+7:8k].
REQ-007 SHALL have port req_last_i  input  NUM_REQ  marks the final byte of a requester's message.
REQ-008 SHALL have port req_ready_o  output  NUM_REQ  per-requester accept; a byte transfers when valid and ready are both high.
REQ-009 SHALL have port tx_fifo_full_i  input  1  TX FIFO full.
REQ-010 SHALL have port tx_fifo_afull_i  input  1  TX FIFO has exactly one free entry.
REQ-011 SHALL have port tx_fifo_wen_o  output  1  registered TX FIFO write strobe.
REQ-012 SHALL have port tx_fifo_wdata_o  output  8  registered TX FIFO write data.
REQ-013 SHALL have port grant_o  output  NUM_REQ  one-hot current owner; all-zero when unlocked.
REQ-014 SHALL have port arb_busy_o  output  1  high while a requester holds the lock.
REQ-015 SHALL have port timeout_o  output  1  one-cycle pulse on forced release; tied 0 without UART_TX_ARB_TIMEOUT_EN.

Function
REQ-016 SHALL implement states IDLE and LOCKED.
REQ-017 In IDLE with any req_valid_i high, SHALL select the first valid requester at or after rr_ptr (wrapping modulo NUM_REQ), register grant_o one-hot, and enter LOCKED next cycle.
REQ-018 In IDLE, req_ready_o SHALL be all-zero; a grant costs one cycle before the first transfer.
REQ-019 In LOCKED, req_ready_o[g] SHALL equal NOT tx_fifo_full_i AND NOT (tx_fifo_wen_o AND tx_fifo_afull_i) for granted g; all other bits zero (combinational).
REQ-020 On a transfer, SHALL assert tx_fifo_wen_o and load tx_fifo_wdata_o with the granted byte on the next cycle; wen lasts exactly one cycle per transfer; back-to-back transfers SHALL give back-to-back writes.
REQ-021 A transfer with req_last_i[g] high SHALL return to IDLE and set rr_ptr to (g+1) mod NUM_REQ; grant_o and arb_busy_o clear the same edge.
REQ-022 Deasserting req_valid_i[g] while LOCKED SHALL NOT release the lock.
REQ-023 A requester SHALL NOT receive a second grant while any other requester was valid at arbitration, given rr_ptr rotation (no starvation).
REQ-024 Simultaneous requests SHALL resolve by rr_ptr order; a requester raising valid during LOCKED waits for the next arbitration.
REQ-025 tx_fifo_wdata_o SHALL hold its last value when tx_fifo_wen_o is low.

Reset
REQ-026 reset_i high SHALL asynchronously force IDLE, rr_ptr=0, grant_o=0, arb_busy_o=0, tx_fifo_wen_o=0, tx_fifo_wdata_o=0, timeout_o=0, stall counter=0.
REQ-027 Reset mid-message SHALL discard the lock with no write strobe emitted for any in-flight byte; first grant after reset goes to requester 0 if valid.

Configuration
REQ-028 Macro UART_TX_ARB_TIMEOUT_EN defined: stall counter clears on each transfer and on grant, increments each LOCKED cycle without transfer; reaching TIMEOUT_CYCLES SHALL force IDLE, advance rr_ptr as REQ-021, and pulse timeout_o one cycle.
REQ-029 Macro undefined: no counter logic; lock held indefinitely; timeout_o constant 0.

Verification
REQ-030 Req0 sends 3 bytes 0x41,0x42,0x43 (last on 0x43), FIFO empty -> wen on 3 consecutive cycles with those data, grant_o 0001 then 0000.
REQ-031 Req0 and req2 valid same cycle after reset -> req0 message first, then req2; next contention req0/req2 -> req2 first if rr_ptr=1..2.
REQ-032 tx_fifo_afull_i=1 with wen pending -> req_ready_o low that cycle; tx_fifo_full_i=1 -> no transfers, no wen, lock held.
REQ-033 reset_i asserted mid-message after 1 of 4 bytes -> all outputs zero asynchronously, no further wen.
REQ-034 With UART_TX_ARB_TIMEOUT_EN, TIMEOUT_CYCLES=8, granted req1 stalls -> timeout_o pulse 8 cycles after last activity, grant moves to waiting req3.
REQ-035 All four requesters continuously valid with 1-byte messages -> grants cycle 0,1,2,3,0.
